// File: rtl/diff_unit.sv
// diff_unit: d-th order differencing stage (d <= MAX_D) with warm-up tracking.
// Ports: clk, reset_n (async active-low, release synchronised internally);
//   c_diff (00 compute, 01/10 hold, 11 clear), d_order (order, latched on first
//   compute after clear/reset), x_in (signed sample); diff_out (registered
//   d-th difference), out_valid (one-cycle result pulse), x_last (last accepted
//   sample), fill_done (warm-up complete), cfg_err (sticky: order clamped to MAX_D).
// Define DIFF_SAT_EN to saturate every stage subtraction instead of wrapping.
module diff_unit #(
  parameter int N     = 32,
  parameter int MAX_D = 3
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [1:0]   c_diff,
  input  logic [N-1:0] d_order,
  input  logic [N-1:0] x_in,
  output logic [N-1:0] diff_out,
  output logic         out_valid,
  output logic [N-1:0] x_last,
  output logic         fill_done,
  output logic         cfg_err
);
  localparam int DW = $clog2(MAX_D + 1);
  typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;
  state_t state_q, state_d;
  logic [1:0] sync_q;
  logic rst_ni;
  logic [MAX_D-1:0][N-1:0] h_q, h_d;
  logic [MAX_D:0][N-1:0] s;
  logic [DW-1:0] d_q, d_d, cnt_q, cnt_d, d_lat;
  logic [N-1:0] dout_q, dout_d, xl_q, xl_d;
  logic vld_q, vld_d, fd_q, fd_d, err_q, err_d, over;

  function automatic logic [N-1:0] sub(input logic [N-1:0] a, input logic [N-1:0] b);
`ifdef DIFF_SAT_EN
    logic [N:0] r;
    r = {a[N-1], a} - {b[N-1], b};
    return (r[N] ^ r[N-1]) ? {r[N], {(N-1){~r[N]}}} : r[N-1:0];
`else
    return a - b;
`endif
  endfunction

  // Assertion is immediate; deassertion reaches the datapath two edges later.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) sync_q <= '0;
    else sync_q <= {sync_q[0], 1'b1};
  assign rst_ni = sync_q[1];

  assign over  = d_order > N'(MAX_D);
  assign d_lat = over ? DW'(MAX_D) : d_order[DW-1:0];

  always_comb begin
    s[0] = x_in;
    for (int k = 0; k < MAX_D; k++) s[k+1] = sub(s[k], h_q[k]);
  end

  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    vld_d   = 1'b0;
    xl_d    = xl_q;
    fd_d    = fd_q;
    err_d   = err_q;
    if (c_diff == 2'b11) begin
      state_d = IDLE;
      h_d     = '0;
      dout_d  = '0;
      cnt_d   = '0;
      fd_d    = 1'b0;
      err_d   = 1'b0;
    end else if (c_diff == 2'b00) begin
      xl_d = x_in;
      h_d  = s[MAX_D-1:0];
      case (state_q)
        IDLE: begin
          d_d     = d_lat;
          err_d   = err_q | over;
          state_d = (d_lat <= DW'(1)) ? RUN : FILL;
          fd_d    = d_lat <= DW'(1);
          vld_d   = d_lat == '0;
          dout_d  = (d_lat == '0) ? x_in : dout_q;
          cnt_d   = (d_lat == '0) ? cnt_q : DW'(1);
        end
        FILL: begin
          cnt_d   = cnt_q + DW'(1);
          state_d = (cnt_q + DW'(1) == d_q) ? RUN : FILL;
          fd_d    = cnt_q + DW'(1) == d_q;
        end
        default: begin
          dout_d = s[d_q];
          vld_d  = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_ni)
    if (!rst_ni) begin
      state_q <= IDLE;
      h_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      dout_q  <= '0;
      vld_q   <= 1'b0;
      xl_q    <= '0;
      fd_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      vld_q   <= vld_d;
      xl_q    <= xl_d;
      fd_q    <= fd_d;
      err_q   <= err_d;
    end

  assign diff_out  = dout_q;
  assign out_valid = vld_q;
  assign x_last    = xl_q;
  assign fill_done = fd_q;
  assign cfg_err   = err_q;
endmodule
